// File: rtl/fifo_mem_ctrl_if.sv
// Write/read handshake and memory bus of the FIFO memory controller.
// Handshake: a word moves on a rising clock edge where valid and ready are both
// high. A producer keeps valid high and the word steady until that edge.
// wready_o depends only on registered state.
interface fifo_mem_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) ();
  logic                wvalid_i;
  logic                wready_o;
  logic [ADDRSIZE-1:0] mem_waddr_o;
  logic                mem_wclken_o;
  logic                mem_wfull_o;
  logic [ADDRSIZE-1:0] mem_raddr_o;
  logic [DATASIZE-1:0] mem_rdata_i;
  logic                rvalid_o;
  logic                rready_i;
  logic [DATASIZE-1:0] rdata_o;

  // Controller side
  modport slave (
    input  wvalid_i, rready_i, mem_rdata_i,
    output wready_o, mem_waddr_o, mem_wclken_o, mem_wfull_o, mem_raddr_o,
           rvalid_o, rdata_o
  );

  // Environment side: producer, consumer and the memory
  modport master (
    output wvalid_i, rready_i, mem_rdata_i,
    input  wready_o, mem_waddr_o, mem_wclken_o, mem_wfull_o, mem_raddr_o,
           rvalid_o, rdata_o
  );
endinterface

// File: rtl/fifo_mem_ctrl.sv
// Single-clock controller for an external dual-port FIFO memory (sync write,
// async read) with one registered show-ahead output stage, so total capacity
// is DEPTH+1 words.
// Optional feature macro: FIFO_CTRL_ERR_EN adds sticky overflow/underflow
// flags (ovf_o, udf_o) with a clear input (err_clr_i).
module fifo_mem_ctrl #(
  parameter int DATASIZE   = 8,
  parameter int ADDRSIZE   = 4,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  fifo_mem_ctrl_if.slave      bus,
  output logic                full_o,
  output logic                empty_o,
  output logic                afull_o,
  output logic                aempty_o,
  output logic [ADDRSIZE:0]   level_o,
`ifdef FIFO_CTRL_ERR_EN
  input  logic                err_clr_i,
  output logic                ovf_o,
  output logic                udf_o,
`endif
  output logic                dbg_state_o
);

  localparam int PW = ADDRSIZE + 1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_VALID = 1'b1
  } out_state_e;

  out_state_e          state_q, state_d;
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [DATASIZE-1:0] rdata_q, rdata_d;

  logic [PW-1:0] mem_cnt;
  logic          mem_empty;
  logic          full;
  logic          wr_acc;
  logic          rvalid;
  logic          pop;
  logic          prefetch;

  // Status comes from registered pointers only; the extra pointer bit tells full from empty.
  assign mem_cnt   = wptr_q - rptr_q;
  assign mem_empty = (wptr_q == rptr_q);
  assign full      = (wptr_q[ADDRSIZE] != rptr_q[ADDRSIZE]) &&
                     (wptr_q[ADDRSIZE-1:0] == rptr_q[ADDRSIZE-1:0]);

  // Write enable is held low during reset so the memory is never written then.
  assign wr_acc = bus.wvalid_i & ~full & rst_ni;
  assign pop    = rvalid & bus.rready_i;

  // State, pointer and output-word registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= OUT_EMPTY;
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  // Output-stage next state: fill when memory has data, drain on the last pop
  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (!mem_empty) state_d = OUT_VALID;
      OUT_VALID: if (pop && mem_empty) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  // Output-stage decode: valid flag and when to pull the next word from memory
  always_comb begin
    rvalid   = 1'b0;
    prefetch = 1'b0;
    case (state_q)
      OUT_EMPTY: prefetch = ~mem_empty;
      OUT_VALID: begin
        rvalid   = 1'b1;
        prefetch = bus.rready_i & ~mem_empty;
      end
      default: begin
        rvalid   = 1'b0;
        prefetch = 1'b0;
      end
    endcase
  end

  // Datapath next values: pointers advance on accept/prefetch, word loads on prefetch
  always_comb begin
    wptr_d  = wptr_q + {{ADDRSIZE{1'b0}}, wr_acc};
    rptr_d  = rptr_q + {{ADDRSIZE{1'b0}}, prefetch};
    rdata_d = prefetch ? bus.mem_rdata_i : rdata_q;
  end

  assign bus.wready_o     = ~full;
  assign bus.mem_waddr_o  = wptr_q[ADDRSIZE-1:0];
  assign bus.mem_wclken_o = wr_acc;
  assign bus.mem_wfull_o  = full;
  assign bus.mem_raddr_o  = rptr_q[ADDRSIZE-1:0];
  assign bus.rvalid_o     = rvalid;
  assign bus.rdata_o      = rdata_q;

  assign full_o      = full;
  assign empty_o     = mem_empty & ~rvalid;
  assign afull_o     = (mem_cnt >= PW'(AFULL_LVL));
  assign aempty_o    = (mem_cnt <= PW'(AEMPTY_LVL));
  assign level_o     = mem_cnt + {{ADDRSIZE{1'b0}}, rvalid};
  assign dbg_state_o = state_q;

`ifdef FIFO_CTRL_ERR_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  // Sticky error flags: a new event wins over a clear in the same cycle
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (err_clr_i) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (bus.wvalid_i & full) ovf_d = 1'b1;
    if (bus.rready_i & ~rvalid) udf_d = 1'b1;
  end

  // Error flag registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

endmodule

// File: tb/tb_fifo_mem_ctrl.sv
// Bench for fifo_mem_ctrl: external memory model, queue-based reference of the
// FIFO (memory contents + one output word), directed and random steps.
module tb_fifo_mem_ctrl;

  localparam int DS    = 8;
  localparam int AS    = 4;
  localparam int DEPTH = 1 << AS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_mem_ctrl_if #(.DATASIZE(DS), .ADDRSIZE(AS)) u_if ();

  logic          full, empty, afull, aempty, dbg_state;
  logic [AS:0]   level;
  logic [DS-1:0] wdata;
`ifdef FIFO_CTRL_ERR_EN
  logic err_clr;
  logic ovf, udf;
`endif

  fifo_mem_ctrl #(.DATASIZE(DS), .ADDRSIZE(AS), .AFULL_LVL(12), .AEMPTY_LVL(2)) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (u_if),
    .full_o     (full),
    .empty_o    (empty),
    .afull_o    (afull),
    .aempty_o   (aempty),
    .level_o    (level),
`ifdef FIFO_CTRL_ERR_EN
    .err_clr_i  (err_clr),
    .ovf_o      (ovf),
    .udf_o      (udf),
`endif
    .dbg_state_o(dbg_state)
  );

  // External memory: synchronous write, asynchronous read
  logic [DS-1:0] mem [DEPTH];
  always @(posedge clk) if (u_if.mem_wclken_o) mem[u_if.mem_waddr_o] <= wdata;
  assign u_if.mem_rdata_i = mem[u_if.mem_raddr_o];

  // ---------------- reference model / scoreboard ----------------
  logic [DS-1:0] exp_q[$];   // words held in the memory, oldest first
  logic          m_ov;       // output word present
  logic [DS-1:0] m_data;     // output word
  logic          m_ovf, m_udf;
  int            exp_next;   // next value expected at a pop in sequence tests
  bit            seq_chk;
  int            n_pop;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = exp_q.size();
    check("rvalid", u_if.rvalid_o, m_ov);
    check("rdata",  u_if.rdata_o, m_data);
    check("level",  level, sz + int'(m_ov));
    check("full",   full, sz == DEPTH);
    check("wfull",  u_if.mem_wfull_o, sz == DEPTH);
    check("wready", u_if.wready_o, sz != DEPTH);
    check("empty",  empty, (sz == 0) && !m_ov);
    check("afull",  afull, sz >= 12);
    check("aempty", aempty, sz <= 2);
    check("wclken", u_if.mem_wclken_o, rst_n && u_if.wvalid_i && (sz != DEPTH));
`ifdef FIFO_CTRL_ERR_EN
    check("ovf", ovf, m_ovf);
    check("udf", udf, m_udf);
`endif
  endtask

  // One clock: advance the model from the current inputs, take the edge, compare
  task automatic cycle();
    bit full_pre, acc, pop, ovf_set, udf_set;
    full_pre = (exp_q.size() == DEPTH);
    acc      = rst_n && u_if.wvalid_i && !full_pre;
    pop      = rst_n && m_ov && u_if.rready_i;
    ovf_set  = u_if.wvalid_i && full_pre;
    udf_set  = u_if.rready_i && !m_ov;
    if (pop) begin
      n_pop++;
      if (seq_chk) begin
        check("pop_seq", u_if.rdata_o, exp_next);
        exp_next++;
      end
    end
    if (!rst_n) begin
      exp_q.delete();
      m_ov   = 1'b0;
      m_data = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
    end else begin
      if (exp_q.size() > 0 && (!m_ov || pop)) begin
        m_data = exp_q.pop_front();
        m_ov   = 1'b1;
      end else if (pop) begin
        m_ov = 1'b0;
      end
      if (acc) exp_q.push_back(wdata);
`ifdef FIFO_CTRL_ERR_EN
      if (ovf_set) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (udf_set) m_udf = 1'b1; else if (err_clr) m_udf = 1'b0;
`endif
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic wv, input logic [DS-1:0] wd, input logic rr);
    u_if.wvalid_i = wv;
    wdata         = wd;
    u_if.rready_i = rr;
  endtask

  task automatic do_reset(input int n);
    drive(1'b0, '0, 1'b0);
    rst_n = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  task automatic start_seq();
    seq_chk  = 1'b1;
    exp_next = 0;
    n_pop    = 0;
  endtask

  // ---------------- directed + random steps ----------------
  initial begin
    int wcnt;
    int guard;
    bit will_acc;
    rst_n    = 1'b0;
    seq_chk  = 1'b0;
    exp_next = 0;
    n_pop    = 0;
    m_ov     = 1'b0;
    m_data   = '0;
    m_ovf    = 1'b0;
    m_udf    = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
    err_clr = 1'b0;
`endif
    drive(1'b0, '0, 1'b0);

    // Reset state
    do_reset(2);
    check("rst_wready", u_if.wready_o, 1);
    check("rst_rvalid", u_if.rvalid_o, 0);
    check("rst_rdata",  u_if.rdata_o, 0);
    check("rst_empty",  empty, 1);
    check("rst_level",  level, 0);
    check("rst_waddr",  u_if.mem_waddr_o, 0);

    // Single write, show-ahead latency
    drive(1'b1, 8'hA5, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b0);
    check("lat_early_rvalid", u_if.rvalid_o, 0);
    cycle();
    check("lat_rvalid", u_if.rvalid_o, 1);
    check("lat_rdata",  u_if.rdata_o, 8'hA5);
    check("lat_level",  level, 1);
    check("lat_empty",  empty, 0);

    // Fill to DEPTH+1 with no reads, then one refused write
    do_reset(1);
    start_seq();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b0);
    cycle();
    check("fill_full",   full, 1);
    check("fill_wready", u_if.wready_o, 0);
    check("fill_level",  level, 17);
    check("fill_afull",  afull, 1);
    drive(1'b1, 8'h11, 1'b0);
    cycle();
    check("fill_refused_level", level, 17);
    drive(1'b0, '0, 1'b1);
    repeat (20) cycle();
    check("fill_drained", n_pop, 17);

    // Streaming 100 words at full rate
    do_reset(1);
    start_seq();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'(i), 1'b1);
      cycle();
    end
    drive(1'b0, '0, 1'b1);
    repeat (4) cycle();
    check("stream_count", n_pop, 100);

    // Random gaps, 40 words, pointers wrap
    do_reset(1);
    start_seq();
    wcnt  = 0;
    guard = 0;
    while ((wcnt < 40 || n_pop < 40) && guard < 3000) begin
      drive((wcnt < 40) ? 1'($urandom_range(0, 1)) : 1'b0, 8'(wcnt),
            1'($urandom_range(0, 1)));
      will_acc = u_if.wvalid_i && (exp_q.size() < DEPTH);
      cycle();
      if (will_acc) wcnt++;
      guard++;
    end
    check("wrap_writes", wcnt, 40);
    check("wrap_count",  n_pop, 40);
    seq_chk = 1'b0;

    // Reset mid-operation with 5 entries
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      cycle();
    end
    drive(1'b0, '0, 1'b0);
    cycle();
    check("mid_rvalid", u_if.rvalid_o, 1);
    check("mid_level",  level, 5);
    do_reset(1);
    check("mid_rst_level",  level, 0);
    check("mid_rst_rvalid", u_if.rvalid_o, 0);

`ifdef FIFO_CTRL_ERR_EN
    // Overflow / underflow flags
    drive(1'b0, '0, 1'b1);
    cycle();
    check("udf_set", udf, 1);
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      cycle();
    end
    check("ovf_before", ovf, 0);
    drive(1'b1, 8'h55, 1'b0);
    cycle();
    check("ovf_set", ovf, 1);
    drive(1'b0, '0, 1'b0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("ovf_clr", ovf, 0);
    check("udf_clr", udf, 0);
    drive(1'b1, 8'h66, 1'b0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    check("ovf_set_wins", ovf, 1);
    do_reset(1);
    check("err_rst", ovf, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
